// File: rtl/pipe_stage_reg.sv
// Two-entry pipeline stage register (head + skid) with valid/ready handshake,
// registered in_ready, halt lock, synchronous flush and saturating
// stall/bubble performance counters.
module pipe_stage_reg #(
    parameter int unsigned       DATA_W      = 16,
    parameter int unsigned       CTRL_W      = 12,
    parameter logic [CTRL_W-1:0] BUBBLE_CTRL = '0,
    parameter int unsigned       CNT_W       = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_halt,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic              out_halt,
    input  logic              flush,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  bubble_cnt
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic              halt_lock_q, halt_lock_d;
    logic              in_ready_q, in_ready_d;
    logic [CTRL_W-1:0] head_ctrl_q, head_ctrl_d;
    logic [DATA_W-1:0] head_data_q, head_data_d;
    logic              head_halt_q, head_halt_d;
    logic [CTRL_W-1:0] skid_ctrl_q, skid_ctrl_d;
    logic [DATA_W-1:0] skid_data_q, skid_data_d;
    logic              skid_halt_q, skid_halt_d;
    logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0]  bubble_cnt_q, bubble_cnt_d;

    logic in_xfer;
    logic out_xfer;
    logic head_valid;

    // Head registers are kept at bubble values while empty, so outputs need no mux.
    assign head_valid = (state_q != EMPTY);
    assign out_valid  = head_valid;
    assign out_ctrl   = head_ctrl_q;
    assign out_data   = head_data_q;
    assign out_halt   = head_halt_q;
    assign in_ready   = in_ready_q;
    assign stall_cnt  = stall_cnt_q;
    assign bubble_cnt = bubble_cnt_q;

    assign in_xfer  = in_valid & in_ready_q;
    assign out_xfer = head_valid & out_ready;

    // Next-state, entry movement, halt lock, registered ready and counters.
    always_comb begin
        state_d      = state_q;
        halt_lock_d  = halt_lock_q;
        head_ctrl_d  = head_ctrl_q;
        head_data_d  = head_data_q;
        head_halt_d  = head_halt_q;
        skid_ctrl_d  = skid_ctrl_q;
        skid_data_d  = skid_data_q;
        skid_halt_d  = skid_halt_q;
        stall_cnt_d  = stall_cnt_q;
        bubble_cnt_d = bubble_cnt_q;

        unique case (state_q)
            EMPTY: begin
                if (in_xfer) begin
                    state_d     = ONE;
                    head_ctrl_d = in_ctrl;
                    head_data_d = in_data;
                    head_halt_d = in_halt;
                end
            end
            ONE: begin
                if (in_xfer && out_xfer) begin
                    head_ctrl_d = in_ctrl;
                    head_data_d = in_data;
                    head_halt_d = in_halt;
                end else if (in_xfer) begin
                    state_d     = TWO;
                    skid_ctrl_d = in_ctrl;
                    skid_data_d = in_data;
                    skid_halt_d = in_halt;
                end else if (out_xfer) begin
                    state_d     = EMPTY;
                    head_ctrl_d = BUBBLE_CTRL;
                    head_data_d = '0;
                    head_halt_d = 1'b0;
                end
            end
            TWO: begin
                if (out_xfer) begin
                    state_d     = ONE;
                    head_ctrl_d = skid_ctrl_q;
                    head_data_d = skid_data_q;
                    head_halt_d = skid_halt_q;
                end
            end
            default: begin
                state_d     = EMPTY;
                head_ctrl_d = BUBBLE_CTRL;
                head_data_d = '0;
                head_halt_d = 1'b0;
            end
        endcase

        if (in_xfer && in_halt) begin
            halt_lock_d = 1'b1;
        end

        // Flush overrides every transfer decided above.
        if (flush) begin
            state_d     = EMPTY;
            halt_lock_d = 1'b0;
            head_ctrl_d = BUBBLE_CTRL;
            head_data_d = '0;
            head_halt_d = 1'b0;
        end

        in_ready_d = (state_d != TWO) && !halt_lock_d;

        // Counters use the pre-flush handshake view of this cycle.
        if (head_valid && !out_ready && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
        if (!head_valid && out_ready && (bubble_cnt_q != '1)) begin
            bubble_cnt_d = bubble_cnt_q + 1'b1;
        end
    end

    // State and payload registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= EMPTY;
            halt_lock_q  <= 1'b0;
            in_ready_q   <= 1'b0;
            head_ctrl_q  <= BUBBLE_CTRL;
            head_data_q  <= '0;
            head_halt_q  <= 1'b0;
            skid_ctrl_q  <= '0;
            skid_data_q  <= '0;
            skid_halt_q  <= 1'b0;
            stall_cnt_q  <= '0;
            bubble_cnt_q <= '0;
        end else begin
            state_q      <= state_d;
            halt_lock_q  <= halt_lock_d;
            in_ready_q   <= in_ready_d;
            head_ctrl_q  <= head_ctrl_d;
            head_data_q  <= head_data_d;
            head_halt_q  <= head_halt_d;
            skid_ctrl_q  <= skid_ctrl_d;
            skid_data_q  <= skid_data_d;
            skid_halt_q  <= skid_halt_d;
            stall_cnt_q  <= stall_cnt_d;
            bubble_cnt_q <= bubble_cnt_d;
        end
    end

endmodule
